alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencing and arbitration front-end for the shared 16-bit ALU. Accepts operation requests from two requesters (requester 0: execute stage, requester 1: address/branch unit) over valid/ready handshakes and grants one at a time. It drives the ALU operand and opcode ports from registers, captures the result and flags Z/N/C/O, and returns them to the granted requester over a response handshake. Sits between the pipeline control logic and the existing combinational ALU.

## Interface
- WIDTH, 16, operand/result width
- OPW, 3, opcode width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid_0 / req_valid_1  in  1  request present
- req_ready_0 / req_ready_1  out  1  request accepted this cycle
- req_a_0 / req_a_1  in  WIDTH  operand A
- req_b_0 / req_b_1  in  WIDTH  operand B
- req_op_0 / req_op_1  in  OPW  ALU opcode
- rsp_valid_0 / rsp_valid_1  out  1  result available for that requester
- rsp_ready_0 / rsp_ready_1  in  1  requester consumes result
- rsp_data  out  WIDTH  result, shared, valid with either rsp_valid
- rsp_flags  out  4  {Z,N,C,O}, shared
- alu_a, alu_b  out  WIDTH  to ALU A/B
- alu_opcode  out  OPW  to ALU opcode
- alu_out  in  WIDTH  from ALU out
- alu_z, alu_n, alu_c, alu_o  in  1  from ALU flags
- busy  out  1  state != IDLE
- grant_id  out  1  requester owning the current transaction

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: the arbiter picks a winner combinationally among asserted req_valid_i and raises only that req_ready_i. On handshake it latches a/b/op into the operand registers, sets grant_id and last_grant, and goes to EXEC. With no valid request it stays in IDLE and both readies are low.
- EXEC: the ALU is driven from the operand registers. alu_out and the flags are latched into the result registers, and the state goes to RESP.
- RESP: rsp_valid_{grant_id} is high and the other rsp_valid is low. The state holds until rsp_ready_{grant_id}, then returns to IDLE. Holding is unbounded, and rsp_data/rsp_flags stay stable throughout.
- Round-robin: when both requesters are valid in IDLE, the requester != last_grant wins. last_grant resets to 1, so requester 0 wins the first tie.
- A single valid requester always wins, regardless of last_grant.
- Request inputs are ignored outside IDLE. Both req_ready signals are low in EXEC and RESP.
- The ALU ports are driven only from registers. In IDLE they keep the last operands (no combinational path from req_* to alu_*).

## Timing
- Reset values: state IDLE, req_ready_* 0 (combinational, IDLE with no valid), rsp_valid_* 0, rsp_data 0, rsp_flags 0, alu_a/alu_b/alu_opcode 0, busy 0, grant_id 0, last_grant 1.
- Latency: handshake in cycle n; rsp_valid asserted in cycle n+2. The earliest next acceptance is the cycle after the response handshake, for a throughput of 1 op per 3 cycles.
- Response handshake completes on the edge where rsp_valid_i && rsp_ready_i. rsp_ready asserted early (in IDLE/EXEC) has no effect.
- A request arriving while busy waits. req_valid must stay high with stable payload until ready.
- Reset asserted mid-transaction (EXEC or RESP) aborts it immediately: no response is delivered and all outputs take their reset values asynchronously.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins ties. last_grant is still tracked but unused.
- Not defined: round-robin as described.

## Structure
- Shared package alu_arb_pkg: state enum (IDLE, EXEC, RESP), flag bit indices (Z=3, N=2, C=1, O=0), WIDTH/OPW defaults.
- One sub-module, alu_arb_pick: combinational winner select from valids, last_grant and macro. Its outputs are grant_vec and grant_id.
- The ALU itself stays outside; the bench instantiates ALU and connects the alu_* ports.

## Test plan
- Requester 0 only, A=10, B=10, op=3'b000 (add) -> req_ready_0 is high for the accept cycle, and rsp_valid_0 is high 2 cycles later with rsp_data=20 and flags Z=0, N=0, C=0, O=0.
- Both valid from reset, r0 add 10+10, r1 op=3'b001 (subtract) 10-10 -> r0 served first (data 20), then r1 (data 0, Z=1). With ALU_ARB_FIXED_PRIO_EN and r0 re-requesting immediately, r0 wins again.
- Backpressure: rsp_ready_0 held low for 5 cycles -> rsp_valid_0 and rsp_data stay stable, busy=1, req_ready_1 stays 0. Response completes on the first rsp_ready_0 high.
- Overflow operands A=16'h7FFF, B=16'h0001 add -> rsp_data=16'h8000, N=1, O=1, C=0.
- Reset asserted during RESP -> rsp_valid_* drops asynchronously, state returns to IDLE, and after release a new request completes normally with last_grant=1 behaviour.
- Request payload changed while busy and not yet accepted -> the value sampled is the one at the handshake cycle only.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared state encoding, flag bit positions and width defaults for alu_arbiter
package alu_arb_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_OPW = 3;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_O = 0;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: combinational winner select; ALU_ARB_FIXED_PRIO_EN gives requester 0 every tie
module alu_arb_pick (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant_vec,
   output logic       grant_id
);
`ifdef ALU_ARB_FIXED_PRIO_EN
   assign grant_id = ~valid[0];
`else
   assign grant_id = (&valid) ? ~last_grant : ~valid[0];
`endif
   assign grant_vec = (|valid) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester sequencer for the shared ALU; define ALU_ARB_FIXED_PRIO_EN for fixed priority
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int OPW = DEF_OPW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_0,
   input  logic             req_valid_1,
   output logic             req_ready_0,
   output logic             req_ready_1,
   input  logic [WIDTH-1:0] req_a_0,
   input  logic [WIDTH-1:0] req_a_1,
   input  logic [WIDTH-1:0] req_b_0,
   input  logic [WIDTH-1:0] req_b_1,
   input  logic [OPW-1:0]   req_op_0,
   input  logic [OPW-1:0]   req_op_1,
   output logic             rsp_valid_0,
   output logic             rsp_valid_1,
   input  logic             rsp_ready_0,
   input  logic             rsp_ready_1,
   output logic [WIDTH-1:0] rsp_data,
   output logic [3:0]       rsp_flags,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_opcode,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_z,
   input  logic             alu_n,
   input  logic             alu_c,
   input  logic             alu_o,
   output logic             busy,
   output logic             grant_id
);
   state_t           r_state;
   logic             r_grant;
   logic             r_last;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_data;
   logic [OPW-1:0]   r_op;
   logic [3:0]       r_flags;
   logic [1:0]       w_grant_vec;
   logic             w_grant_id;
   logic             w_idle;
   logic             w_rsp_hs;
   alu_arb_pick u_pick (
      .valid      ({req_valid_1, req_valid_0}),
      .last_grant (r_last),
      .grant_vec  (w_grant_vec),
      .grant_id   (w_grant_id)
   );
   assign w_idle = r_state == IDLE;
   assign req_ready_0 = w_idle & w_grant_vec[0];
   assign req_ready_1 = w_idle & w_grant_vec[1];
   assign rsp_valid_0 = (r_state == RESP) & ~r_grant;
   assign rsp_valid_1 = (r_state == RESP) & r_grant;
   assign w_rsp_hs = r_grant ? rsp_ready_1 : rsp_ready_0;
   assign rsp_data = r_data;
   assign rsp_flags = r_flags;
   assign alu_a = r_a;
   assign alu_b = r_b;
   assign alu_opcode = r_op;
   assign busy = ~w_idle;
   assign grant_id = r_grant;
   // last_grant resets to 1 so requester 0 takes the first tie
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         r_grant <= 1'b0;
         r_last <= 1'b1;
         r_a <= '0;
         r_b <= '0;
         r_op <= '0;
         r_data <= '0;
         r_flags <= '0;
      end else
         case (r_state)
            IDLE: if (|w_grant_vec) begin
               r_a <= w_grant_id ? req_a_1 : req_a_0;
               r_b <= w_grant_id ? req_b_1 : req_b_0;
               r_op <= w_grant_id ? req_op_1 : req_op_0;
               r_grant <= w_grant_id;
               r_last <= w_grant_id;
               r_state <= EXEC;
            end
            EXEC: begin
               r_data <= alu_out;
               r_flags[FLAG_Z] <= alu_z;
               r_flags[FLAG_N] <= alu_n;
               r_flags[FLAG_C] <= alu_c;
               r_flags[FLAG_O] <= alu_o;
               r_state <= RESP;
            end
            RESP: if (w_rsp_hs) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized scoreboard bench for alu_arbiter driving a behavioural ALU
module tb_alu_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic req_valid_0 = 1'b0, req_valid_1 = 1'b0, rsp_ready_0 = 1'b0, rsp_ready_1 = 1'b0;
   logic [15:0] req_a_0 = '0, req_b_0 = '0, req_a_1 = '0, req_b_1 = '0;
   logic [2:0] req_op_0 = '0, req_op_1 = '0;
   logic req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, busy, grant_id;
   logic [15:0] rsp_data, alu_a, alu_b, alu_out;
   logic [3:0] rsp_flags;
   logic [2:0] alu_opcode;
   logic alu_z, alu_n, alu_c, alu_o;
   logic [16:0] alu_s;
   typedef struct {
      bit id;
      logic [15:0] a, b, d;
      logic [2:0] op;
      logic [3:0] f;
      int cyc;
   } exp_t;
   exp_t sb[$];
   int n_tests = 0, n_fail = 0, cyc = 0;
   bit m_idle = 1'b1, m_last = 1'b1, rnd = 1'b0;
   alu_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
      .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
      .req_a_0(req_a_0), .req_a_1(req_a_1), .req_b_0(req_b_0), .req_b_1(req_b_1),
      .req_op_0(req_op_0), .req_op_1(req_op_1),
      .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
      .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
      .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_o(alu_o),
      .busy(busy), .grant_id(grant_id)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // stand-in for the external combinational ALU
   always_comb begin
      alu_s = '0;
      alu_c = 1'b0;
      alu_o = 1'b0;
      case (alu_opcode)
         3'd0: begin
            alu_s = {1'b0, alu_a} + {1'b0, alu_b};
            alu_c = alu_s[16];
            alu_o = (alu_a[15] == alu_b[15]) && (alu_s[15] != alu_a[15]);
         end
         3'd1: begin
            alu_s = {1'b0, alu_a} - {1'b0, alu_b};
            alu_c = alu_s[16];
            alu_o = (alu_a[15] != alu_b[15]) && (alu_s[15] != alu_a[15]);
         end
         3'd2: alu_s[15:0] = alu_a & alu_b;
         3'd3: alu_s[15:0] = alu_a | alu_b;
         3'd4: alu_s[15:0] = alu_a ^ alu_b;
         3'd5: alu_s[15:0] = alu_a;
         3'd6: alu_s[15:0] = alu_b;
         default: alu_s[15:0] = ~alu_a;
      endcase
      alu_out = alu_s[15:0];
      alu_z = alu_s[15:0] == 16'd0;
      alu_n = alu_s[15];
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask
   // expected {data, Z, N, C, O} from integer arithmetic
   function automatic logic [19:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
      int ua, ub, sa, sb2, r;
      bit c, o;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb2 = int'($signed(b));
      c = 1'b0;
      o = 1'b0;
      case (op)
         3'd0: begin r = ua + ub; c = r > 65535; o = (sa + sb2 > 32767) || (sa + sb2 < -32768); end
         3'd1: begin r = ua - ub; c = ua < ub; o = (sa - sb2 > 32767) || (sa - sb2 < -32768); end
         3'd2: r = ua & ub;
         3'd3: r = ua | ub;
         3'd4: r = ua ^ ub;
         3'd5: r = ua;
         3'd6: r = ub;
         default: r = 65535 - ua;
      endcase
      r = r & 65535;
      return {16'(r), r == 0, r > 32767, c, o};
   endfunction
   function automatic bit pick(input bit v0, input bit v1, input bit last);
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (v0) return 1'b0;
      return 1'b1;
`else
      if (v0 && v1) return (last == 1'b1) ? 1'b0 : 1'b1;
      if (v0) return 1'b0;
      return 1'b1;
`endif
   endfunction
   function automatic logic [15:0] rv();
      case ($urandom_range(5))
         0: return 16'h7FFF;
         1: return 16'h8000;
         2: return 16'hFFFF;
         3: return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction
   // monitor + scoreboard
   always @(negedge clk) begin
      bit w;
      logic [1:0] v, gv;
      exp_t e;
      v = {req_valid_1, req_valid_0};
      if (rst) begin
         chk("rst_rsp_valid", 32'({rsp_valid_1, rsp_valid_0}), 0);
         chk("rst_rsp_data", 32'(rsp_data), 0);
         chk("rst_rsp_flags", 32'(rsp_flags), 0);
         chk("rst_alu_a", 32'(alu_a), 0);
         chk("rst_alu_b", 32'(alu_b), 0);
         chk("rst_alu_op", 32'(alu_opcode), 0);
         chk("rst_busy_gid", 32'({busy, grant_id}), 0);
         if (v == 2'b00) chk("rst_req_ready", 32'({req_ready_1, req_ready_0}), 0);
         sb.delete();
         m_idle = 1'b1;
         m_last = 1'b1;
      end else begin
         w = pick(v[0], v[1], m_last);
         gv = (m_idle && v != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
         chk("req_ready", 32'({req_ready_1, req_ready_0}), 32'(gv));
         chk("busy", 32'(busy), 32'(!m_idle));
         if (gv != 2'b00) begin
            e.id = w;
            e.a = w ? req_a_1 : req_a_0;
            e.b = w ? req_b_1 : req_b_0;
            e.op = w ? req_op_1 : req_op_0;
            {e.d, e.f} = ref_alu(e.a, e.b, e.op);
            e.cyc = cyc + 2;
            sb.push_back(e);
            m_last = w;
            m_idle = 1'b0;
         end
         if (sb.size() == 0 || cyc < sb[0].cyc)
            chk("rsp_valid_early", 32'({rsp_valid_1, rsp_valid_0}), 0);
         if (sb.size() != 0 && cyc >= sb[0].cyc - 1) begin
            chk("grant_id", 32'(grant_id), 32'(sb[0].id));
            chk("alu_a", 32'(alu_a), 32'(sb[0].a));
            chk("alu_b", 32'(alu_b), 32'(sb[0].b));
            chk("alu_op", 32'(alu_opcode), 32'(sb[0].op));
         end
         if (sb.size() != 0 && cyc >= sb[0].cyc) begin
            chk("rsp_valid", 32'({rsp_valid_1, rsp_valid_0}), sb[0].id ? 32'd2 : 32'd1);
            chk("rsp_data", 32'(rsp_data), 32'(sb[0].d));
            chk("rsp_flags", 32'(rsp_flags), 32'(sb[0].f));
            if (sb[0].id ? rsp_ready_1 : rsp_ready_0) begin
               void'(sb.pop_front());
               m_idle = 1'b1;
            end
         end
      end
   end
   task automatic step();
      bit a0, a1;
      @(negedge clk);
      a0 = req_valid_0 && req_ready_0;
      a1 = req_valid_1 && req_ready_1;
      @(posedge clk);
      #1;
      if (a0) req_valid_0 = 1'b0;
      if (a1) req_valid_1 = 1'b0;
      if (rnd) begin
         if (!req_valid_0 && $urandom_range(2) == 0) begin
            req_valid_0 = 1'b1; req_a_0 = rv(); req_b_0 = rv(); req_op_0 = 3'($urandom);
         end else if (req_valid_0 && busy && $urandom_range(3) == 0) req_a_0 = rv();
         if (!req_valid_1 && $urandom_range(2) == 0) begin
            req_valid_1 = 1'b1; req_a_1 = rv(); req_b_1 = rv(); req_op_1 = 3'($urandom);
         end else if (req_valid_1 && busy && $urandom_range(3) == 0) req_b_1 = rv();
         rsp_ready_0 = $urandom_range(2) != 0;
         rsp_ready_1 = $urandom_range(2) != 0;
      end
   endtask
   task automatic drain(input int maxc);
      int k;
      k = 0;
      while ((req_valid_0 || req_valid_1 || sb.size() != 0) && k < maxc) begin
         step();
         k++;
      end
      chk("drain_in_time", 32'(k < maxc), 1);
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      rsp_ready_0 = 1'b1;
      rsp_ready_1 = 1'b1;
      req_a_0 = 16'd10; req_b_0 = 16'd10; req_op_0 = 3'd0; req_valid_0 = 1'b1;
      drain(20);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      req_a_0 = 16'd10; req_b_0 = 16'd10; req_op_0 = 3'd0; req_valid_0 = 1'b1;
      req_a_1 = 16'd10; req_b_1 = 16'd10; req_op_1 = 3'd1; req_valid_1 = 1'b1;
      drain(20);
      // held response with a waiting requester whose payload changes before acceptance
      rsp_ready_0 = 1'b0;
      req_a_0 = 16'h7FFF; req_b_0 = 16'h0001; req_op_0 = 3'd0; req_valid_0 = 1'b1;
      step();
      req_a_1 = 16'd3; req_b_1 = 16'd4; req_op_1 = 3'd0; req_valid_1 = 1'b1;
      repeat (6) begin
         step();
         chk("bp_ready_1", 32'(req_ready_1), 0);
         chk("bp_rsp_valid_0", 32'(rsp_valid_0), 1);
         chk("bp_rsp_data", 32'(rsp_data), 32'h8000);
         chk("bp_rsp_flags", 32'(rsp_flags), 32'b0101);
      end
      req_a_1 = 16'h0100;
      rsp_ready_0 = 1'b1;
      drain(20);
      // reset while a response is pending
      rsp_ready_0 = 1'b0;
      req_a_0 = 16'd5; req_b_0 = 16'd7; req_op_0 = 3'd1; req_valid_0 = 1'b1;
      for (int k = 0; k < 10 && !rsp_valid_0; k++) step();
      chk("resp_reached", 32'(rsp_valid_0), 1);
      #1 rst = 1'b1;
      #1;
      chk("async_rsp_valid", 32'({rsp_valid_1, rsp_valid_0}), 0);
      chk("async_busy", 32'(busy), 0);
      chk("async_rsp_data", 32'(rsp_data), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rsp_ready_0 = 1'b1;
      req_a_0 = 16'h1234; req_b_0 = 16'h0FFF; req_op_0 = 3'd2; req_valid_0 = 1'b1;
      req_a_1 = 16'h8000; req_b_1 = 16'h0001; req_op_1 = 3'd1; req_valid_1 = 1'b1;
      drain(20);
      rnd = 1'b1;
      repeat (600) step();
      rnd = 1'b0;
      rsp_ready_0 = 1'b1;
      rsp_ready_1 = 1'b1;
      drain(50);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
